// File: rtl/uart_tx_arbiter.sv
// Two-source byte arbiter in front of a single uart_tx: grants one byte at a time,
// drives the TX_DV/TX_Byte handshake, waits for frame completion, then acks the owner.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CLKS = 2048,
    parameter bit PRIO_FIXED   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req0,
    input  logic [7:0] i_byte0,
    input  logic       i_lock0,
    output logic       o_ack0,
    input  logic       i_req1,
    input  logic [7:0] i_byte1,
    input  logic       i_lock1,
    output logic       o_ack1,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_dv,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic       o_owner,
    output logic       o_busy,
    output logic       o_timeout
);
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_WAIT_ACT  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_owner;
    logic          r_lock_hold;
    logic          r_owner;
    logic [7:0]    r_tx_byte;
    logic          r_tx_dv;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_busy;
    logic          r_timeout;

    logic [1:0]    w_req;
    logic          w_win;

    assign w_req = {i_req1, i_req0};

    // A held lock beats priority; otherwise fixed priority or round-robin on last_owner.
    always_comb begin
        w_win = 1'b0;
        if (r_lock_hold && w_req[r_owner])
            w_win = r_owner;
        else if (PRIO_FIXED)
            w_win = !i_req0;
        else
            w_win = w_req[~r_last_owner] ? ~r_last_owner : r_last_owner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_owner <= 1'b1;
            r_lock_hold  <= 1'b0;
            r_owner      <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_tx_dv      <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_tx_dv   <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_lock_hold && !w_req[r_owner])
                        r_lock_hold <= 1'b0;
                    // Never start a frame over one still in flight (uart_tx ignores rst_n).
                    if ((i_req0 || i_req1) && !i_tx_active) begin
                        r_tx_byte <= w_win ? i_byte1 : i_byte0;
                        r_owner   <= w_win;
                        r_tx_dv   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_ACT;
                end
                S_WAIT_ACT, S_WAIT_DONE: begin
                    if (i_tx_done) begin
                        r_ack0  <= !r_owner;
                        r_ack1  <= r_owner;
                        r_state <= S_ACK;
                    end else if (r_state == S_WAIT_ACT && i_tx_active) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_timeout    <= 1'b1;
                        r_lock_hold  <= 1'b0;
                        r_last_owner <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    r_last_owner <= r_owner;
                    r_lock_hold  <= r_owner ? i_lock1 : i_lock0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_byte = r_tx_byte;
    assign o_tx_dv   = r_tx_dv;
    assign o_ack0    = r_ack0;
    assign o_ack1    = r_ack1;
    assign o_owner   = r_owner;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;
endmodule
